// File: rtl/wb_demux_pkg.sv
// ----------------------------------------------------------------------------
// wb_demux_pkg
// Purpose : shared constants for the write-back demultiplexer slice.
//           Holds the default data width and FIFO depth, the channel select
//           encoding (same polarity as the datapath operand mux) and the
//           reset-active level.
// Contents: WB_WIDTH, WB_DEPTH, SEL_CH1, SEL_CH2, RST_ACT, sel_is_ch1()
// ----------------------------------------------------------------------------
package wb_demux_pkg;

    localparam int   WB_WIDTH = 8;
    localparam int   WB_DEPTH = 2;

    // Channel select encoding: 1 -> accumulator side, 0 -> data-memory side.
    localparam logic SEL_CH1  = 1'b1;
    localparam logic SEL_CH2  = 1'b0;

    // Reset is asserted when rst equals this level.
    localparam logic RST_ACT  = 1'b0;

    // True when the select value steers to channel 1.
    function automatic logic sel_is_ch1(input logic sel);
        return (sel == SEL_CH1);
    endfunction

endpackage

// File: rtl/wb_demux_if.sv
// ----------------------------------------------------------------------------
// wb_demux_if
// Purpose : bundles the result-stream input handshake, the two channel
//           output handshakes and the occupancy observation ports.
// Modports: master - producer/consumer side (drives in_*, outN_ready)
//           slave  - the demultiplexer itself
// Signals : in_valid/in_data/in_sel/in_ready, outN_valid/outN_data/outN_ready,
//           occ1/occ2 (width $clog2(DEPTH+1))
// ----------------------------------------------------------------------------
interface wb_demux_if
    import wb_demux_pkg::*;
#(
    parameter int WIDTH = WB_WIDTH,
    parameter int DEPTH = WB_DEPTH
);

    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_ready;

    logic             out1_valid;
    logic [WIDTH-1:0] out1_data;
    logic             out1_ready;

    logic             out2_valid;
    logic [WIDTH-1:0] out2_data;
    logic             out2_ready;

    logic [CW-1:0]    occ1;
    logic [CW-1:0]    occ2;

    modport master (
        output in_valid, in_data, in_sel, out1_ready, out2_ready,
        input  in_ready, out1_valid, out1_data, out2_valid, out2_data,
               occ1, occ2
    );

    modport slave (
        input  in_valid, in_data, in_sel, out1_ready, out2_ready,
        output in_ready, out1_valid, out1_data, out2_valid, out2_data,
               occ1, occ2
    );

endinterface

// File: rtl/wb_demux_fifo.sv
// ----------------------------------------------------------------------------
// wb_demux_fifo
// Purpose : per-channel FIFO of the write-back demultiplexer.
//           Registered storage, read/write pointers wrapping modulo DEPTH and
//           an occupancy counter covering 0..DEPTH inclusive.
// Ports   : clk   in  rising-edge clock
//           rst   in  asynchronous active-low reset
//           push  in  write din at the tail (ignored when full)
//           din   in  data to write
//           full  out occupancy == DEPTH
//           pop   in  remove head entry (ignored when empty)
//           dout  out head entry, 0 when empty
//           valid out occupancy != 0
//           occ   out occupancy
// ----------------------------------------------------------------------------
module wb_demux_fifo
    import wb_demux_pkg::*;
#(
    parameter int WIDTH = WB_WIDTH,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    output logic                         full,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    occ_r;
    logic [CW-1:0]    occ_nxt_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             valid_s;

    // Status flags and qualified push/pop; a full FIFO ignores push and an
    // empty one ignores pop, so the counter can never leave 0..DEPTH.
    always_comb begin
        full_s  = (occ_r == CW'(DEPTH));
        valid_s = (occ_r != {CW{1'b0}});
        push_s  = push & ~full_s;
        pop_s   = pop & valid_s;
    end

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        occ_nxt_s = occ_r;
        case ({push_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + CW'(1);
            2'b01:   occ_nxt_s = occ_r - CW'(1);
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is
    // a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACT) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            occ_r    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            occ_r <= occ_nxt_s;
        end
    end

    // Outputs are taken straight from registered state; the head is masked to
    // zero while empty so stale entries never appear on the bus.
    always_comb begin
        full  = full_s;
        valid = valid_s;
        occ   = occ_r;
        if (valid_s) begin
            dout = mem_r[rd_ptr_r];
        end else begin
            dout = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/wb_demux.sv
// ----------------------------------------------------------------------------
// wb_demux
// Purpose : write-back demultiplexer. Steers the ALU result stream to
//           channel 1 (accumulator side, in_sel=1) or channel 2 (data-memory
//           side, in_sel=0). Each channel is buffered by its own FIFO so a
//           stalled consumer does not block the other channel.
// Ports   : clk  in  rising-edge clock
//           rst  in  asynchronous active-low reset
//           bus  wb_demux_if.slave - in_valid/in_data/in_sel/in_ready,
//                outN_valid/outN_data/outN_ready, occ1/occ2
// ----------------------------------------------------------------------------
module wb_demux
    import wb_demux_pkg::*;
#(
    parameter int WIDTH = WB_WIDTH,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    wb_demux_if.slave   bus
);

    logic full1_s;
    logic full2_s;
    logic in_ready_s;
    logic push1_s;
    logic push2_s;

    // in_ready depends only on in_sel and registered occupancy: a pop in the
    // same cycle deliberately does not open space for a push.
    always_comb begin
        in_ready_s = 1'b0;
        case (bus.in_sel)
            SEL_CH1: in_ready_s = ~full1_s;
            SEL_CH2: in_ready_s = ~full2_s;
            default: in_ready_s = 1'b0;
        endcase
        push1_s = bus.in_valid & in_ready_s &  sel_is_ch1(bus.in_sel);
        push2_s = bus.in_valid & in_ready_s & ~sel_is_ch1(bus.in_sel);
    end

    assign bus.in_ready = in_ready_s;

    wb_demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_ch1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1_s),
        .din   (bus.in_data),
        .full  (full1_s),
        .pop   (bus.out1_ready),
        .dout  (bus.out1_data),
        .valid (bus.out1_valid),
        .occ   (bus.occ1)
    );

    wb_demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_ch2 (
        .clk   (clk),
        .rst   (rst),
        .push  (push2_s),
        .din   (bus.in_data),
        .full  (full2_s),
        .pop   (bus.out2_ready),
        .dout  (bus.out2_data),
        .valid (bus.out2_valid),
        .occ   (bus.occ2)
    );

endmodule

// File: tb/tb_wb_demux.sv
// ----------------------------------------------------------------------------
// tb_wb_demux
// Self-checking bench for wb_demux. A queue per channel models the FIFOs:
// accept when the selected queue holds fewer than DEPTH entries, pop the front
// when the consumer is ready and the queue is non-empty.
// ----------------------------------------------------------------------------
module tb_wb_demux;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst;

    int total;
    int bad;

    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] q2[$];
    logic [WIDTH-1:0] del1[$];
    logic [WIDTH-1:0] del2[$];

    wb_demux_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    wb_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, first rising edge at 5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs and let combinational logic settle.
    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic s,
                         input logic r1, input logic r2);
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.in_sel     = s;
        bus.out1_ready = r1;
        bus.out2_ready = r2;
        #1;
    endtask

    // Advance one clock edge and update the reference queues from the inputs
    // present at that edge; returns 1 time unit after the edge.
    task automatic tick();
        logic             acc;
        logic             p1;
        logic             p2;
        logic             s;
        logic [WIDTH-1:0] d;
        s   = bus.in_sel;
        d   = bus.in_data;
        acc = bus.in_valid && (s ? (q1.size() < DEPTH) : (q2.size() < DEPTH));
        p1  = bus.out1_ready && (q1.size() > 0);
        p2  = bus.out2_ready && (q2.size() > 0);
        @(posedge clk);
        if (p1) del1.push_back(q1.pop_front());
        if (p2) del2.push_back(q2.pop_front());
        if (acc) begin
            if (s) q1.push_back(d);
            else   q2.push_back(d);
        end
        #1;
    endtask

    // Empty both channels with an idle input.
    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (bus.out1_valid !== 1'b0) begin bad++; $display("FAIL reset_out1_valid got=%0b exp=0", bus.out1_valid); end
        total++; if (bus.out2_valid !== 1'b0) begin bad++; $display("FAIL reset_out2_valid got=%0b exp=0", bus.out2_valid); end
        total++; if (bus.out1_data !== 8'h00) begin bad++; $display("FAIL reset_out1_data got=%h exp=00", bus.out1_data); end
        total++; if (bus.out2_data !== 8'h00) begin bad++; $display("FAIL reset_out2_data got=%h exp=00", bus.out2_data); end
        total++; if (bus.occ1 !== 2'd0) begin bad++; $display("FAIL reset_occ1 got=%0d exp=0", bus.occ1); end
        total++; if (bus.occ2 !== 2'd0) begin bad++; $display("FAIL reset_occ2 got=%0d exp=0", bus.occ2); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
        rst = 1'b1;
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h6B, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        total++; if (bus.occ1 !== 2'd2) begin bad++; $display("FAIL mid_fill_occ1 got=%0d exp=2", bus.occ1); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_fill_in_ready got=%0b exp=0", bus.in_ready); end
        #1;
        rst = 1'b0;
        #1;
        q1.delete(); q2.delete();
        total++; if (bus.out1_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out1_valid got=%0b exp=0", bus.out1_valid); end
        total++; if (bus.occ1 !== 2'd0) begin bad++; $display("FAIL mid_rst_occ1 got=%0d exp=0", bus.occ1); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready got=%0b exp=1", bus.in_ready); end
        total++; if (bus.out1_data !== 8'h00) begin bad++; $display("FAIL mid_rst_out1_data got=%h exp=00", bus.out1_data); end
        rst = 1'b1;
        #1;
    endtask

    task automatic test_routing();
        drain();
        drive(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL route_in_ready got=%0b exp=1", bus.in_ready); end
        tick();
        total++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 8'hA5) begin bad++; $display("FAIL route_ch1 got=%0b/%h exp=1/a5", bus.out1_valid, bus.out1_data); end
        total++; if (bus.out2_valid !== 1'b0) begin bad++; $display("FAIL route_ch2_idle got=%0b exp=0", bus.out2_valid); end
        drive(1'b1, 8'h3C, 1'b0, 1'b1, 1'b1);
        tick();
        total++; if (bus.out2_valid !== 1'b1 || bus.out2_data !== 8'h3C) begin bad++; $display("FAIL route_ch2 got=%0b/%h exp=1/3c", bus.out2_valid, bus.out2_data); end
        total++; if (bus.out1_valid !== 1'b0 || del1.size() == 0 || del1[del1.size()-1] !== 8'hA5) begin bad++; $display("FAIL route_ch1_popped got=%0b exp=0", bus.out1_valid); end
    endtask

    task automatic test_full();
        drain();
        drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        total++; if (bus.occ1 !== 2'd2) begin bad++; $display("FAIL full_occ1 got=%0d exp=2", bus.occ1); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%0b exp=0", bus.in_ready); end
        tick();
        total++; if (bus.occ1 !== 2'd2 || bus.out1_data !== 8'h11) begin bad++; $display("FAIL full_no_store got=%0d/%h exp=2/11", bus.occ1, bus.out1_data); end
        // Ready on the full channel must not open space for a same-cycle push.
        drive(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_no_pop_path got=%0b exp=0", bus.in_ready); end
        drive(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL full_other_ready got=%0b exp=1", bus.in_ready); end
        tick();
        total++; if (bus.occ2 !== 2'd1 || bus.out2_data !== 8'h44) begin bad++; $display("FAIL full_other_accept got=%0d/%h exp=1/44", bus.occ2, bus.out2_data); end
        total++; if (bus.occ1 !== 2'd2) begin bad++; $display("FAIL full_ch1_hold got=%0d exp=2", bus.occ1); end
    endtask

    task automatic test_push_pop();
        drain();
        drive(1'b1, 8'h11, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL pp_in_ready got=%0b exp=1", bus.in_ready); end
        tick();
        total++; if (bus.occ1 !== 2'd1) begin bad++; $display("FAIL pp_occ1 got=%0d exp=1", bus.occ1); end
        total++; if (bus.out1_data !== 8'h22) begin bad++; $display("FAIL pp_head got=%h exp=22", bus.out1_data); end
        total++; if (del1.size() == 0 || del1[del1.size()-1] !== 8'h11) begin bad++; $display("FAIL pp_popped got=%0d entries exp last=11", del1.size()); end
    endtask

    task automatic test_wrap();
        int sent;
        int cyc;
        logic [WIDTH-1:0] v;
        drain();
        del2.delete();
        sent = 0;
        cyc  = 0;
        while (del2.size() < 10 && cyc < 400) begin
            v = 8'(sent + 1);
            drive(sent < 10, v, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
            cyc++;
            total++;
            if (bus.occ2 !== CW'(q2.size()) || bus.out2_valid !== (q2.size() > 0) ||
                bus.out2_data !== ((q2.size() > 0) ? q2[0] : 8'h00)) begin
                bad++;
                $display("FAIL wrap_cycle%0d got=%0d/%0b/%h exp=%0d/%0b/%h", cyc, bus.occ2,
                         bus.out2_valid, bus.out2_data, q2.size(), q2.size() > 0,
                         (q2.size() > 0) ? q2[0] : 8'h00);
            end
        end
        total++; if (del2.size() != 10) begin bad++; $display("FAIL wrap_count got=%0d exp=10", del2.size()); end
        for (int i = 0; i < 10 && i < del2.size(); i++) begin
            total++;
            if (del2[i] !== 8'(i + 1)) begin bad++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", i, del2[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_empty_pop();
        drain();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0);
            tick();
            total++;
            if (bus.occ1 !== 2'd0 || bus.out1_data !== 8'h00 || bus.out1_valid !== 1'b0) begin
                bad++;
                $display("FAIL empty_pop cyc=%0d got=%0d/%h/%0b exp=0/00/0", i, bus.occ1, bus.out1_data, bus.out1_valid);
            end
        end
    endtask

    task automatic test_random();
        logic exp_rdy;
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            exp_rdy = bus.in_sel ? (q1.size() < DEPTH) : (q2.size() < DEPTH);
            total++;
            if (bus.in_ready !== exp_rdy) begin bad++; $display("FAIL rand_in_ready cyc=%0d got=%0b exp=%0b", i, bus.in_ready, exp_rdy); end
            tick();
            total++;
            if (bus.occ1 !== CW'(q1.size()) || bus.out1_valid !== (q1.size() > 0) ||
                bus.out1_data !== ((q1.size() > 0) ? q1[0] : 8'h00)) begin
                bad++;
                $display("FAIL rand_ch1 cyc=%0d got=%0d/%h exp=%0d/%h", i, bus.occ1, bus.out1_data,
                         q1.size(), (q1.size() > 0) ? q1[0] : 8'h00);
            end
            total++;
            if (bus.occ2 !== CW'(q2.size()) || bus.out2_valid !== (q2.size() > 0) ||
                bus.out2_data !== ((q2.size() > 0) ? q2[0] : 8'h00)) begin
                bad++;
                $display("FAIL rand_ch2 cyc=%0d got=%0d/%h exp=%0d/%h", i, bus.occ2, bus.out2_data,
                         q2.size(), (q2.size() > 0) ? q2[0] : 8'h00);
            end
        end
    endtask

    // Test sequence.
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_reset_midstream();
        test_routing();
        test_full();
        test_push_pop();
        test_wrap();
        test_empty_pop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
